// File: rtl/rom_loader.sv
// UART boot loader: receives 8N1 bytes, parses A5/count/words/checksum packets
// and writes 16-bit words into the instruction ROM while holding the CPU in reset.
module rom_loader #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        wr_en,
  output logic [14:0] wr_adr,
  output logic [15:0] wr_data,
  output logic        cpu_reset,
  output logic        done,
  output logic        err
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_HOLD} rx_state_e;
  typedef enum logic [2:0] {P_IDLE, P_CNT_HI, P_CNT_LO, P_DATA_HI, P_DATA_LO, P_CHECK} pk_state_e;

  // ---------------- byte receiver ----------------
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       rst_q, rst_d;
  logic [CW-1:0]   bcnt_q, bcnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            stop_tick, byte_valid, frame_err;
  logic [7:0]      rx_byte;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      rst_q     <= R_IDLE;
      bcnt_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      rst_q     <= rst_d;
      bcnt_q    <= bcnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    rst_d   = rst_q;
    bcnt_d  = bcnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    case (rst_q)
      R_IDLE: begin
        bcnt_d = '0;
        bit_d  = '0;
        if (rx_prev_q && !rx_sync_q) rst_d = R_START;
      end
      R_START: if (bcnt_q == HALF_M1) begin
        // still high at mid start bit: a glitch, not a frame
        bcnt_d = '0;
        rst_d  = rx_sync_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (bcnt_q == FULL_M1) begin
        bcnt_d  = '0;
        shift_d = {rx_sync_q, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) rst_d = R_STOP;
      end
      R_STOP: if (bcnt_q == FULL_M1) begin
        bcnt_d = '0;
        rst_d  = rx_sync_q ? R_IDLE : R_HOLD;
      end
      R_HOLD: begin
        bcnt_d = '0;
        if (rx_sync_q) rst_d = R_IDLE;
      end
      default: rst_d = R_IDLE;
    endcase
  end

  always_comb begin
    stop_tick  = (rst_q == R_STOP) && (bcnt_q == FULL_M1);
    byte_valid = stop_tick && rx_sync_q;
    frame_err  = stop_tick && !rx_sync_q;
    rx_byte    = shift_q;
  end

  // ---------------- packet FSM ----------------
  pk_state_e   pst_q, pst_d;
  logic [7:0]  cnt_hi_q, cnt_hi_d;
  logic [15:0] rem_q, rem_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  chk_q, chk_d;
  logic [14:0] adr_q, adr_d;
  logic [15:0] data_q, data_d;
  logic        wen_q, wen_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] cnt_n;

  assign cnt_n = {cnt_hi_q, rx_byte};

  always_ff @(posedge clk) begin
    if (!reset) begin
      pst_q     <= P_IDLE;
      cnt_hi_q  <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      chk_q     <= '0;
      adr_q     <= '0;
      data_q    <= '0;
      wen_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pst_q     <= pst_d;
      cnt_hi_q  <= cnt_hi_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      chk_q     <= chk_d;
      adr_q     <= adr_d;
      data_q    <= data_d;
      wen_q     <= wen_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    pst_d = pst_q;
    if (frame_err) begin
      pst_d = P_IDLE;
    end else if (byte_valid) begin
      case (pst_q)
        P_IDLE:    if (rx_byte == 8'hA5) pst_d = P_CNT_HI;
        P_CNT_HI:  pst_d = P_CNT_LO;
        P_CNT_LO: begin
          if (cnt_n > 16'h8000)     pst_d = P_IDLE;
          else if (cnt_n == 16'd0)  pst_d = P_CHECK;
          else                      pst_d = P_DATA_HI;
        end
        P_DATA_HI: pst_d = P_DATA_LO;
        P_DATA_LO: pst_d = (rem_q == 16'd1) ? P_CHECK : P_DATA_HI;
        P_CHECK:   pst_d = P_IDLE;
        default:   pst_d = P_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_hi_d  = cnt_hi_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    chk_d     = chk_q;
    data_d    = data_q;
    wen_d     = 1'b0;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    // address advances on the edge that ends the write strobe
    adr_d     = wen_q ? adr_q + 15'd1 : adr_q;
    if (frame_err) begin
      err_d  = 1'b1;
      done_d = 1'b0;
    end else if (byte_valid) begin
      if (pst_q != P_IDLE && pst_q != P_CHECK) chk_d = chk_q ^ rx_byte;
      case (pst_q)
        P_IDLE: if (rx_byte == 8'hA5) begin
          cpu_rst_d = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          adr_d     = '0;
          chk_d     = '0;
        end
        P_CNT_HI: cnt_hi_d = rx_byte;
        P_CNT_LO: begin
          rem_d = cnt_n;
          if (cnt_n > 16'h8000) err_d = 1'b1;
        end
        P_DATA_HI: hi_d = rx_byte;
        P_DATA_LO: begin
          data_d = {hi_q, rx_byte};
          wen_d  = 1'b1;
          rem_d  = rem_q - 16'd1;
        end
        P_CHECK: begin
          if (rx_byte == chk_q) begin
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_en     = wen_q;
  assign wr_adr    = adr_q;
  assign wr_data   = data_q;
  assign cpu_reset = cpu_rst_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/rom_loader.md
# rom_loader

Serial boot loader that fills the instruction ROM from a UART byte stream while the CPU is held in reset. It receives an 8N1 serial stream, validates a framed packet and emits one 16-bit write per instruction word on the ROM write port. It releases the CPU once a correct checksum arrives. It is the writer for the instruction memory that the CPU only ever reads, and it sits beside the computer top, driving the CPU reset input.

## Interface
- CLKS_PER_BIT, 16, clock cycles per UART bit; even, ≥ 4
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- rx  in  1  UART serial input, idle high, 8N1, LSB first; asynchronous to clk
- wr_en  out  1  one-cycle ROM write strobe
- wr_adr  out  15  ROM word address
- wr_data  out  16  ROM write data
- cpu_reset  out  1  active-high reset to the CPU; held while loading
- done  out  1  level; last packet loaded with a good checksum
- err  out  1  level; last packet aborted (framing, length or checksum)

## Operation
- rx passes through a 2-flop synchronizer before any use.
- **Byte receiver:**
  - A synchronized falling edge starts a frame.
  - At +CLKS_PER_BIT/2 the receiver samples again. If the sample is high, it is a false start: ignore it and return to idle.
  - It then takes 8 data samples, one every CLKS_PER_BIT, LSB first, followed by a stop sample.
  - Stop = 1: the byte is accepted (internal one-cycle byte_valid).
  - Stop = 0: framing error. Set err, send the packet FSM to IDLE, and wait for rx high before hunting for the next start.
- **Packet format:** 0xA5, CNT_HI, CNT_LO, then N = {CNT_HI, CNT_LO} words as big-endian byte pairs, then CHK.
  - CHK = XOR of every byte after the header, up to but excluding CHK.
- **Packet FSM states:** IDLE → CNT_HI → CNT_LO → DATA_HI → DATA_LO → (repeat) → CHECK → IDLE.
  - IDLE: ignores every byte except 0xA5.
  - On 0xA5: cpu_reset=1, done=0, err=0, wr_adr=0, checksum cleared.
  - CNT_LO: if N > 32768, set err and go to IDLE. If N = 0, go directly to CHECK.
  - DATA_LO: loads wr_data = {hi, lo} and pulses wr_en. After the pulse, wr_adr increments.
  - After word N the FSM goes to CHECK.
  - CHECK on match: done=1, cpu_reset=0.
  - CHECK on mismatch: err=1, cpu_reset stays 1.
  - Both outcomes return to IDLE.
- A new 0xA5 after done restarts loading and re-asserts cpu_reset. Words already written are simply overwritten.
- wr_adr is 15-bit. The increment after word 32768 wraps to 0, and no further writes occur.
- done and err are never 1 simultaneously.

## Timing
- **Reset values** (reset=0 at a clk edge): wr_en=0, wr_adr=0, wr_data=0, cpu_reset=1, done=0, err=0. The receiver and FSM go to idle/IDLE, and the checksum register is 0.
- **Mid-packet reset** discards the packet. Outputs return to reset values in the same edge.
- **Byte latency:** byte_valid fires CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the synchronizer output first shows the start-bit low.
- **wr_en:** high for exactly one cycle, the cycle after the low data byte's byte_valid.
  - wr_adr and wr_data are stable during that cycle.
  - wr_adr increments on the following edge.
- **done / cpu_reset / err:** change on the cycle after CHK's byte_valid.
- Back-to-back bytes with no idle time between the stop bit and the next start bit must be received correctly.

## Test plan
- **Reset:** hold reset=0 for 3 cycles with rx toggling → all outputs at reset values, and no wr_en.
- **One-word load:** A5 00 01 12 34 27 → single wr_en with wr_adr=0, wr_data=0x1234; then done=1, cpu_reset=0, err=0.
- **Bad checksum:** A5 00 02 00 01 00 02 FF → two writes (adr 0 data 0x0001, adr 1 data 0x0002); then err=1, done=0, cpu_reset=1.
- **Framing and glitches:**
  - Stop bit forced low on CNT_LO → err=1 and no writes. A following good packet then loads normally and clears err.
  - A 2-cycle low glitch on rx → no byte accepted.
- **Zero count and oversize:**
  - A5 00 00 00 → done=1, no wr_en.
  - A5 80 01 → err=1 immediately after CNT_LO.
- **Reload and reset mid-packet:**
  - After done, send A5 00 01 AB CD 67 → cpu_reset rises at the header, then one write at adr 0, then done=1.
  - Assert reset during DATA_HI → outputs return to reset values, and the rest of the stream is ignored until the next 0xA5.
